// File: rtl/rr_mux_arbiter_4ch_pkg.sv
// Shared constants, FSM state type and round-robin pointer helper
// for the four-channel arbiter slice.
package rr_mux_arbiter_4ch_pkg;

    localparam logic [1:0]  CH_A       = 2'd0;
    localparam logic [1:0]  CH_B       = 2'd1;
    localparam logic [1:0]  CH_C       = 2'd2;
    localparam logic [1:0]  CH_D       = 2'd3;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Pointer advances to the channel after the winner, wrapping D -> A.
    function automatic logic [1:0] rr_next(input logic [1:0] grant);
        if (grant == CH_D) begin
            return CH_A;
        end
        return grant + 2'd1;
    endfunction

endpackage

// File: rtl/multiplexer_4to1_32bit.sv
// Existing 4:1 datapath multiplexer for 32-bit words.
module multiplexer_4to1_32bit
    import rr_mux_arbiter_4ch_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [DATA_WIDTH-1:0] C,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            CH_A:    out = A;
            CH_B:    out = B;
            CH_C:    out = C;
            default: out = D;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter_4ch.sv
// Round-robin arbiter over four valid/ready producers, driving the 4:1 mux
// and holding the selected word in a registered valid/ready output stage.
module rr_mux_arbiter_4ch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    input  logic [DATA_WIDTH-1:0] in_data_a,
    input  logic [DATA_WIDTH-1:0] in_data_b,
    input  logic [DATA_WIDTH-1:0] in_data_c,
    input  logic [DATA_WIDTH-1:0] in_data_d,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_src,
    output logic [1:0]            mux_sel,
    output logic [CNT_WIDTH-1:0]  xfer_count
);
    import rr_mux_arbiter_4ch_pkg::*;

    out_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            src_q, src_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;

    logic [1:0]            grant;
    logic [1:0]            idx;
    logic                  grant_vld;
    logic                  load_en;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] mux_out;

    // First valid channel at or after rr_ptr, searching modulo 4.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!grant_vld && in_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign mux_sel = grant_vld ? grant : rr_ptr_q;

    multiplexer_4to1_32bit u_mux (
        .A   (in_data_a),
        .B   (in_data_b),
        .C   (in_data_c),
        .D   (in_data_d),
        .sel (mux_sel),
        .out (mux_out)
    );

    // rst_n gates load_en so no handshake can complete in a reset cycle.
    assign out_valid = (state_q == ST_FULL);
    assign load_en   = rst_n && (!out_valid || out_ready);
    assign xfer      = load_en && grant_vld;
    assign in_ready  = xfer ? (4'(1) << grant) : '0;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;

        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (xfer) begin
            data_d   = mux_out;
            src_d    = grant;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            rr_ptr_d = rr_next(grant);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            src_q    <= CH_A;
            cnt_q    <= '0;
            rr_ptr_q <= CH_A;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data   = data_q;
    assign out_src    = src_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4ch.sv
// Directed bench for rr_mux_arbiter_4ch; a second instance with a 4-bit
// counter shares the inputs to exercise counter wrap.
module tb_rr_mux_arbiter_4ch;

    localparam logic [31:0] WA = 32'hAAAA_5555;
    localparam logic [31:0] WB = 32'hBBBB_6666;
    localparam logic [31:0] WC = 32'hCCCC_7777;
    localparam logic [31:0] WD = 32'hDDDD_8888;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic        out_ready;

    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic [1:0]  mux_sel;
    logic [15:0] xfer_count;

    logic [3:0]  in_ready_c4;
    logic        out_valid_c4;
    logic [31:0] out_data_c4;
    logic [1:0]  out_src_c4;
    logic [1:0]  mux_sel_c4;
    logic [3:0]  xfer_count_c4;

    int checks;
    int failures;

    rr_mux_arbiter_4ch #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data_a  (in_data_a),
        .in_data_b  (in_data_b),
        .in_data_c  (in_data_c),
        .in_data_d  (in_data_d),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .mux_sel    (mux_sel),
        .xfer_count (xfer_count)
    );

    rr_mux_arbiter_4ch #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut_c4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data_a  (in_data_a),
        .in_data_b  (in_data_b),
        .in_data_c  (in_data_c),
        .in_data_d  (in_data_d),
        .in_ready   (in_ready_c4),
        .out_valid  (out_valid_c4),
        .out_ready  (out_ready),
        .out_data   (out_data_c4),
        .out_src    (out_src_c4),
        .mux_sel    (mux_sel_c4),
        .xfer_count (xfer_count_c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || xfer_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h s=%0d c=%0d expected v=0 d=0 s=0 c=0",
                     out_valid, out_data, out_src, xfer_count);
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_single();
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_in_ready: got %b expected 0001", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== WA || out_src !== 2'd0 || xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL single_out: got v=%b d=%h s=%0d c=%0d expected v=1 d=%h s=0 c=1",
                     out_valid, out_data, out_src, xfer_count, WA);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== WA) begin
            failures++;
            $display("FAIL single_drain: got v=%b d=%h expected v=0 d=%h", out_valid, out_data, WA);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_src [5];
        logic [31:0] exp_dat [5];
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{WA, WB, WC, WD, WA};
        apply_reset();
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src[i] || out_data !== exp_dat[i]) begin
                failures++;
                $display("FAIL rr_step%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         i, out_valid, out_src, out_data, exp_src[i], exp_dat[i]);
            end
        end
        checks++;
        if (xfer_count !== 16'd5) begin
            failures++;
            $display("FAIL rr_count: got %0d expected 5", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        checks++;
        if (out_data !== WB || out_src !== 2'd1 || xfer_count !== 16'd6) begin
            failures++;
            $display("FAIL bp_fill: got d=%h s=%0d c=%0d expected d=%h s=1 c=6",
                     out_data, out_src, xfer_count, WB);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_in_ready%0d: got %b expected 0000", i, in_ready);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== WB || out_src !== 2'd1 || xfer_count !== 16'd6) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d c=%0d expected v=1 d=%h s=1 c=6",
                         i, out_valid, out_data, out_src, xfer_count, WB);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100 || mux_sel !== 2'd2) begin
            failures++;
            $display("FAIL bp_resume_ready: got r=%b sel=%0d expected r=0100 sel=2", in_ready, mux_sel);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== WC || out_src !== 2'd2 || xfer_count !== 16'd7) begin
            failures++;
            $display("FAIL bp_resume: got v=%b d=%h s=%0d c=%0d expected v=1 d=%h s=2 c=7",
                     out_valid, out_data, out_src, xfer_count, WC);
        end
    endtask

    task automatic test_skip_wrap();
        in_valid = 4'b0010;
        #1;
        checks++;
        if (in_ready !== 4'b0010 || mux_sel !== 2'd1) begin
            failures++;
            $display("FAIL wrap_grant: got r=%b sel=%0d expected r=0010 sel=1", in_ready, mux_sel);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== WB || xfer_count !== 16'd8) begin
            failures++;
            $display("FAIL wrap_out: got v=%b s=%0d d=%h c=%0d expected v=1 s=1 d=%h c=8",
                     out_valid, out_src, out_data, xfer_count, WB);
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (mux_sel !== 2'd2) begin
            failures++;
            $display("FAIL wrap_ptr: got sel=%0d expected 2", mux_sel);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== WB || out_src !== 2'd1) begin
            failures++;
            $display("FAIL wrap_drain: got v=%b d=%h s=%0d expected v=0 d=%h s=1",
                     out_valid, out_data, out_src, WB);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== WC) begin
            failures++;
            $display("FAIL mid_fill: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, WC);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_in_ready: got %b expected 0000", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_count !== 16'd0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset: got v=%b d=%h c=%0d r=%b expected v=0 d=0 c=0 r=0000",
                     out_valid, out_data, xfer_count, in_ready);
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (mux_sel !== 2'd0) begin
            failures++;
            $display("FAIL mid_ptr: got sel=%0d expected 0", mux_sel);
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        repeat (17) @(negedge clk);
        in_valid = 4'b0000;
        checks++;
        if (xfer_count_c4 !== 4'd1) begin
            failures++;
            $display("FAIL cnt4_wrap: got %0d expected 1", xfer_count_c4);
        end
        checks++;
        if (xfer_count !== 16'd17) begin
            failures++;
            $display("FAIL cnt16_count: got %0d expected 17", xfer_count);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data_a = WA;
        in_data_b = WB;
        in_data_c = WC;
        in_data_d = WD;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_reset_mid();
        test_counter_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4ch.md
Name: rr_mux_arbiter_4ch

Overview:
- Four-channel round-robin arbiter and output register stage that sits directly upstream of, and wraps, the multiplexer_4to1_32bit datapath mux.
- Each of four 32-bit producers offers a word with a valid/ready handshake.
- The arbiter generates the 2-bit mux select and captures the muxed word into a registered valid/ready output.
- It also reports the source channel id and keeps a running transfer count.

Parameters:
- DATA_WIDTH, 32, word width; fixed to match multiplexer_4to1_32bit.
- CNT_WIDTH, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  4  per-channel valid; bit i belongs to channel i (A=0, B=1, C=2, D=3).
- in_data_a  input  32  channel 0 word.
- in_data_b  input  32  channel 1 word.
- in_data_c  input  32  channel 2 word.
- in_data_d  input  32  channel 3 word.
- in_ready  output  4  per-channel ready; one-hot or zero.
- out_valid  output  1  registered word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  32  registered muxed word.
- out_src  output  2  channel id of out_data.
- mux_sel  output  2  current select driven to the mux (observability).
- xfer_count  output  CNT_WIDTH  number of completed input transfers.

Behaviour:
- Reset (rst_n=0 at a rising clk edge): out_valid=0, out_data=0, out_src=0, xfer_count=0, rr_ptr=0. While rst_n=0, in_ready=0.
- Reset mid-operation: any held word is discarded and no handshake completes in that cycle.
- load_en = !out_valid || out_ready. The output stage can accept a word when it is empty or is being drained this cycle, giving throughput of 1 word/cycle.
- Arbitration is combinational from in_valid and rr_ptr:
  - Search channels in order rr_ptr, rr_ptr+1, ..., modulo 4.
  - The first channel with valid set is grant; grant_vld=1 if any channel is valid.
  - mux_sel = grant when grant_vld, else rr_ptr.
- in_ready[grant] = load_en && grant_vld; all other bits are 0. Never more than one bit is set.
- An input transfer on channel i occurs when in_valid[i] && in_ready[i].
- On an input transfer, at the next clk edge:
  - out_data <= mux output (word of channel grant); out_src <= grant; out_valid <= 1.
  - rr_ptr <= grant+1 (mod 4, wrapping 3 -> 0).
  - xfer_count <= xfer_count+1, wrapping at 2^CNT_WIDTH-1 -> 0.
- Output drain with no new transfer: if out_valid && out_ready, then out_valid <= 0 at the next edge; out_data and out_src hold their values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1 with no bubble.
- Backpressure: while out_valid && !out_ready, out_data and out_src are stable, in_ready=0, and rr_ptr is frozen.
- Latency: exactly 1 cycle from the input handshake to out_valid.
- Fairness: a continuously valid channel waits at most 3 transfers.
- Producer rule: a producer must hold its valid and data until it sees ready; the arbiter relies on this and does not re-check it.
- A channel dropping valid before it is granted is legal; arbitration re-evaluates every cycle.
- State machine, derived from out_valid:
  - EMPTY goes to FULL on an input transfer; otherwise it stays EMPTY.
  - FULL goes to EMPTY on a drain with no transfer.
  - FULL stays FULL on a drain with a transfer, or on a stall.

Decomposition:
- Shared package holds:
  - CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3;
  - NUM_CH=4;
  - DATA_WIDTH=32;
  - the round-robin next-pointer helper function.
- One sub-module: instantiate the existing multiplexer_4to1_32bit with A..D = in_data_a..d, sel = mux_sel. Its out feeds the out_data register.

Test Plan:
- Reset, then a single request: hold rst_n=0 for 2 cycles, release, drive in_valid=4'b0001 with in_data_a=32'hAAAA_5555 and out_ready=1. Expect in_ready=4'b0001 the same cycle; next cycle out_valid=1, out_data=32'hAAAA_5555, out_src=0, xfer_count=1.
- Round robin: hold in_valid=4'b1111 (A=AAAA_5555, B=BBBB_6666, C=CCCC_7777, D=DDDD_8888) with out_ready=1 for 5 cycles. Expect out_src sequence 0,1,2,3,0, with out_data matching each source and out_valid held at 1.
- Backpressure: with the output full (out_data=BBBB_6666) and out_ready=0 for 3 cycles, expect in_ready=0, out_data stable, xfer_count unchanged. Raising out_ready resumes with the next word from channel 2 with no bubble.
- Skip and wrap: rr_ptr=3, in_valid=4'b0010. Expect grant 1 (D skipped, wrap through A); rr_ptr becomes 2.
- Reset mid-operation: with out_valid=1, out_data=CCCC_7777, assert rst_n=0 for one edge. Expect out_valid=0, out_data=0, xfer_count=0, in_ready=0.
- Counter wrap: set CNT_WIDTH=4 and perform 17 transfers. Expect xfer_count=1.
